// File: rtl/module_detector_error_if.sv
// Codeword input and decoded-result output bundle of the SECDED error detector.
// master = producer of received codewords, slave = the detector.
interface module_detector_error_if;
    logic [7:0] datos_recibidos;
    logic       valid_in;
    logic [2:0] sindrome;
    logic       paridad_global;
    logic       bit_error;
    logic       error_doble;
    logic [3:0] datos_corregidos;
    logic       valid_out;

    modport master (
        output datos_recibidos,
        output valid_in,
        input  sindrome,
        input  paridad_global,
        input  bit_error,
        input  error_doble,
        input  datos_corregidos,
        input  valid_out
    );

    modport slave (
        input  datos_recibidos,
        input  valid_in,
        output sindrome,
        output paridad_global,
        output bit_error,
        output error_doble,
        output datos_corregidos,
        output valid_out
    );
endinterface

// File: rtl/module_detector_error.sv
// SECDED (Hamming 7,4 + global parity) decoder: one-cycle registered syndrome,
// single/double error flags and corrected data nibble.
module module_detector_error (
    input  logic                          clk,
    input  logic                          rst_n,
    module_detector_error_if.slave        bus
);

    localparam int unsigned WORD_W = 8;
    localparam int unsigned SYN_W  = 3;
    localparam int unsigned DATA_W = 4;

    typedef struct packed {
        logic [SYN_W-1:0]  sindrome;
        logic              paridad_global;
        logic              bit_error;
        logic              error_doble;
        logic [DATA_W-1:0] datos_corregidos;
    } result_t;

    logic [WORD_W-1:0] word_c;
    logic [WORD_W-1:0] fixed_word_c;
    logic [SYN_W-1:0]  syn_c;
    logic              par_c;
    result_t           res_d;
    result_t           res_q;
    logic              valid_q;

    // Syndrome, overall parity, flag decode and single-bit correction
    always_comb begin
        word_c       = bus.datos_recibidos;
        syn_c        = '0;
        par_c        = 1'b0;
        fixed_word_c = word_c;
        res_d        = '0;

        syn_c[0] = word_c[1] ^ word_c[3] ^ word_c[5] ^ word_c[7];
        syn_c[1] = word_c[2] ^ word_c[3] ^ word_c[6] ^ word_c[7];
        syn_c[2] = word_c[4] ^ word_c[5] ^ word_c[6] ^ word_c[7];
        par_c    = ^word_c;

        // Only an odd-parity word with a nonzero syndrome points at a flippable position
        if (par_c && (syn_c != '0)) begin
            fixed_word_c[syn_c] = ~word_c[syn_c];
        end

        res_d.sindrome         = syn_c;
        res_d.paridad_global   = par_c;
        res_d.bit_error        = par_c;
        res_d.error_doble      = (!par_c) && (syn_c != '0);
        res_d.datos_corregidos = {fixed_word_c[7], fixed_word_c[6],
                                  fixed_word_c[5], fixed_word_c[3]};
    end

    // Result register: loads on valid_in, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.valid_in;
            if (bus.valid_in) begin
                res_q <= res_d;
            end
        end
    end

    assign bus.sindrome         = res_q.sindrome;
    assign bus.paridad_global   = res_q.paridad_global;
    assign bus.bit_error        = res_q.bit_error;
    assign bus.error_doble      = res_q.error_doble;
    assign bus.datos_corregidos = res_q.datos_corregidos;
    assign bus.valid_out        = valid_q;

endmodule

// File: tb/tb_module_detector_error.sv
// Self-checking bench for module_detector_error: directed SECDED cases, reset/hold,
// and random words against a position-arithmetic reference model.
module tb_module_detector_error;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    logic [10:0] last_exp;

    module_detector_error_if bus ();

    module_detector_error dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {sindrome, paridad_global, bit_error, error_doble, datos_corregidos, valid_out}
    function automatic logic [10:0] observed();
        return {bus.sindrome, bus.paridad_global, bus.bit_error, bus.error_doble,
                bus.datos_corregidos, bus.valid_out};
    endfunction

    // Reference: syndrome is the XOR of the indices of all set Hamming positions
    function automatic logic [10:0] model(input logic [7:0] w);
        int         s;
        int         ones;
        logic       par;
        logic       be;
        logic       ed;
        logic [7:0] c;
        s    = 0;
        ones = 0;
        for (int p = 0; p < 8; p++) begin
            if (w[p]) begin
                ones++;
                if (p != 0) s = s ^ p;
            end
        end
        par = ((ones % 2) == 1);
        be  = par;
        ed  = (s != 0) && !par;
        c   = w;
        if (par && s != 0) c[s] = ~c[s];
        return {3'(s), par, be, ed, c[7], c[6], c[5], c[3], 1'b1};
    endfunction

    task automatic check(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = observed();
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] w, input logic v);
        @(negedge clk);
        bus.datos_recibidos = w;
        bus.valid_in        = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        logic       v;
        logic [10:0] e;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.datos_recibidos = 8'h00;
        bus.valid_in        = 1'b0;
        #2;
        check("reset_state", 11'b0);
        @(posedge clk);
        #1;
        check("reset_held", 11'b0);

        // First word accepted at the first edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        bus.datos_recibidos = 8'h00;
        bus.valid_in        = 1'b1;
        @(posedge clk);
        #1;
        check("clean_zero", 11'b000_0_0_0_0000_1);

        for (int i = 1; i < 8; i++) begin
            w = 8'h01 << i;
            send(w, 1'b1);
            check($sformatf("single_pos%0d", i), {3'(i), 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1});
        end
        send(8'h01, 1'b1);
        check("single_pos0", 11'b000_1_1_0_0000_1);

        send(8'b0000_0011, 1'b1);
        check("double_err", 11'b001_0_0_1_0000_1);

        send(8'b1101_1111, 1'b1);
        check("correct_pos5", 11'b101_1_1_0_1111_1);

        send(8'hFF, 1'b1);
        check("valid_ff", 11'b000_0_0_0_1111_1);
        last_exp = 11'b000_0_0_0_1111_1;

        // valid_in low: outputs hold, valid_out drops
        send(8'h55, 1'b0);
        check("hold_1", {last_exp[10:1], 1'b0});
        send(8'h03, 1'b0);
        check("hold_2", {last_exp[10:1], 1'b0});

        // Mid-stream asynchronous reset; word sampled during reset is discarded
        send(8'h03, 1'b1);
        check("pre_reset", 11'b001_0_0_1_0000_1);
        @(negedge clk);
        bus.datos_recibidos = 8'hDF;
        bus.valid_in        = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 11'b0);
        @(posedge clk);
        #1;
        check("reset_discard", 11'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.datos_recibidos = 8'h20;
        @(posedge clk);
        #1;
        check("post_reset_word", model(8'h20));
        last_exp = model(8'h20);

        // Random stream with random valid gaps
        for (int k = 0; k < 300; k++) begin
            w = 8'($urandom_range(0, 255));
            v = ($urandom_range(0, 3) != 0);
            send(w, v);
            if (v) e = model(w);
            else   e = {last_exp[10:1], 1'b0};
            check($sformatf("rand_%0d_w%02h_v%0d", k, w, v), e);
            last_exp = e;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/module_detector_error.md
MODULE_DETECTOR_ERROR -- requirements
Module: module_detector_error

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as listed below.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 datos_recibidos  input  8  received SECDED codeword; bit 0 = global parity, bits 1..7 = Hamming positions 1..7.
REQ-005 valid_in  input  1  qualifies datos_recibidos; sampled on the clk rising edge.
REQ-006 sindrome  output  3  registered Hamming syndrome, equal to the erroneous position 1..7, or 0 if none.
REQ-007 paridad_global  output  1  registered XOR of all 8 received bits; 1 = odd overall parity.
REQ-008 bit_error  output  1  registered single-bit (correctable) error flag.
REQ-009 error_doble  output  1  registered double-bit (uncorrectable) error flag.
REQ-010 datos_corregidos  output  4  registered corrected data nibble {pos7, pos6, pos5, pos3}.
REQ-011 valid_out  output  1  high for exactly one cycle per accepted word; marks valid outputs.

Function
REQ-012 Code layout: parity bits SHALL sit at positions 1, 2 and 4; data bits SHALL sit at positions 3, 5, 6 and 7.
REQ-013 Syndrome bits SHALL be computed as follows.
- sindrome[0] = XOR of positions 1, 3, 5, 7.
- sindrome[1] = XOR of positions 2, 3, 6, 7.
- sindrome[2] = XOR of positions 4, 5, 6, 7.
REQ-014 paridad_global SHALL be the XOR of datos_recibidos[7:0].
REQ-015 Flag decode SHALL follow this table.
- sindrome=0, paridad_global=0: no error; both flags 0.
- paridad_global=1: single error; bit_error=1, error_doble=0. Position = sindrome, or the global parity bit 0 when sindrome=0.
- sindrome!=0, paridad_global=0: double error; bit_error=0, error_doble=1.
REQ-016 bit_error and error_doble SHALL never both be 1.
REQ-017 On a single error at position 1..7, that bit SHALL be inverted before datos_corregidos is extracted.
REQ-018 On a parity-bit-only error (position 1, 2, 4 or 0), datos_corregidos SHALL equal the received data bits.
REQ-019 On a double error, datos_corregidos SHALL carry the uncorrected received data bits.
REQ-020 Latency: all outputs SHALL reflect the word sampled at edge N immediately after edge N (one cycle).
REQ-021 When valid_in=1 at an edge, all outputs SHALL update and valid_out SHALL go to 1.
REQ-022 When valid_in=0 at an edge, valid_out SHALL go to 0 and the other outputs SHALL hold their previous values.
REQ-023 Back-to-back valid_in SHALL be accepted every cycle with no stall; there is no backpressure.
REQ-024 Only registered flops SHALL drive the outputs; there SHALL be no combinational input-to-output path.

Reset
REQ-025 While rst_n=0, all outputs SHALL be 0 asynchronously: sindrome=000, paridad_global=0, bit_error=0, error_doble=0, datos_corregidos=0000, valid_out=0.
REQ-026 Reset asserted mid-stream SHALL discard any word sampled in the same cycle.
REQ-027 The first word SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-028 The bench SHALL cover the following directed scenarios.
- Clean all-zero word: datos_recibidos=8'b0000_0000, valid_in=1 -> next cycle sindrome=000, paridad_global=0, bit_error=0, error_doble=0, valid_out=1.
- Single-bit sweep: for i=1..7, datos_recibidos=(1<<i) -> sindrome=i, paridad_global=1, bit_error=1, error_doble=0, datos_corregidos=0000. For i=0 -> sindrome=000, paridad_global=1, bit_error=1, error_doble=0.
- Double error: datos_recibidos=8'b0000_0011 -> sindrome=001, paridad_global=0, bit_error=0, error_doble=1.
- Correction of a data bit: datos_recibidos=8'b1101_1111 (valid 8'hFF with position 5 flipped) -> sindrome=101, paridad_global=1, bit_error=1, datos_corregidos=1111.
- Valid codeword: datos_recibidos=8'hFF -> sindrome=000, paridad_global=0, both flags 0, datos_corregidos=1111.
- Reset and hold: pulse rst_n low during a streaming burst -> all outputs 0 immediately. Drop valid_in with changing data -> outputs hold and valid_out=0.
